// File: rtl/pipeline_mem_access_pkg.sv
// Shared configuration for the memory-access (M) stage.
// Holds the datapath width, the writeback-select and access-size encodings,
// and the encodings of the bus-handshake FSM states.
// XLEN defaults to 32 and can be overridden with `define XLEN before compiling.
`ifndef XLEN
`define XLEN 32
`endif

package pipeline_mem_access_pkg;

  localparam int XLEN = `XLEN;

  // Writeback result select
  localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

  // Access size masks, right-justified before lane shifting
  localparam logic [3:0] BYTE_SEL_B = 4'b0001;
  localparam logic [3:0] BYTE_SEL_H = 4'b0011;
  localparam logic [3:0] BYTE_SEL_W = 4'b1111;

  // Bus handshake FSM
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

endpackage

// File: rtl/pipeline_mem_access_load_extract.sv
// load_extract: aligns the addressed byte/half/word of a read word to bit 0
// and sign- or zero-extends it. Purely combinational.
// Ports:
//   i_rdata     read word from the data bus
//   i_addr_lo   byte offset within the word
//   i_byte_sel  access size mask (byte / half / word)
//   i_unsigned  1 = zero-extend, 0 = sign-extend
//   o_data      extended load value
module load_extract
  import pipeline_mem_access_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_addr_lo,
  input  logic [3:0]      i_byte_sel,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  // NOTE: every branch (including default) assigns o_data, so no latch is inferred.
  always_comb begin
    case (i_byte_sel)
      BYTE_SEL_B: o_data = {{(XLEN-8){~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      BYTE_SEL_H: o_data = {{(XLEN-16){~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default:    o_data = w_shifted;  // word loads pass straight through
    endcase
  end

endmodule

// File: rtl/pipeline_mem_access.sv
// pipeline_mem_access: memory-access pipeline stage.
// Drives the data-memory req/ack bus from the M-stage register, stalls the
// upstream pipeline while an access is outstanding, extracts load data and
// registers the result into the M/W pipeline register.
// Optional feature: define DMEM_TIMEOUT_EN to enable an ack watchdog that
// aborts an access after TIMEOUT_CYCLES cycles in WAIT (flagged on o_bus_err).
// Ports:
//   i_clk, i_rstn              clock, asynchronous active-low reset
//   i_ctrl_*M, i_alu_resultM,
//   i_mem_writedataM,
//   i_regfile_rd_addrM,
//   i_PCPlus4M                 M-stage pipeline register fields
//   o_dmem_* / i_dmem_*        data-memory request/ack bus
//   o_stallM                   holds the E/M register and earlier stages
//   o_misaligned, o_bus_err    one-cycle registered error flags
//   o_*W                       M/W pipeline register outputs
module pipeline_mem_access
  import pipeline_mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_ctrl_reg_wr_enM,
  input  logic [1:0]      i_ctrl_result_srcM,
  input  logic            i_ctrl_mem_wr_enM,
  input  logic [3:0]      i_ctrl_mem_byte_selM,
  input  logic            i_ctrl_mem_unsignedM,
  input  logic [XLEN-1:0] i_alu_resultM,
  input  logic [XLEN-1:0] i_mem_writedataM,
  input  logic [4:0]      i_regfile_rd_addrM,
  input  logic [XLEN-1:0] i_PCPlus4M,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_wstrb,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_stallM,
  output logic            o_misaligned,
  output logic            o_bus_err,
  output logic            o_ctrl_reg_wr_enW,
  output logic [1:0]      o_ctrl_result_srcW,
  output logic [XLEN-1:0] o_alu_resultW,
  output logic [XLEN-1:0] o_read_dataW,
  output logic [4:0]      o_regfile_rd_addrW,
  output logic [XLEN-1:0] o_PCPlus4W
);

  if ((2 ** TIMEOUT_W) <= TIMEOUT_CYCLES) begin : g_bad_timeout_cfg
    $error("TIMEOUT_W is too narrow to count to TIMEOUT_CYCLES");
  end

  logic [0:0]      r_state;
  logic            w_mem_op;
  logic            w_misalign;
  logic            w_misalign_acc;
  logic            w_access;
  logic            w_timeout;
  logic            w_stall;
  logic [XLEN-1:0] w_load_data;

  assign w_mem_op   = (i_ctrl_result_srcM == RESULT_SRC_MEM) | i_ctrl_mem_wr_enM;
  assign w_misalign = ((i_ctrl_mem_byte_selM == BYTE_SEL_H) & i_alu_resultM[0]) |
                      ((i_ctrl_mem_byte_selM == BYTE_SEL_W) & (i_alu_resultM[1:0] != 2'b00));
  assign w_misalign_acc = w_mem_op & w_misalign;
  assign w_access       = w_mem_op & ~w_misalign;

  // Qualified with i_rstn so an in-flight request drops the instant reset asserts.
  assign w_stall      = w_access & ~i_dmem_ack & ~w_timeout & i_rstn;
  assign o_stallM     = w_stall;
  assign o_dmem_req   = w_access & i_rstn;
  assign o_dmem_we    = i_ctrl_mem_wr_enM;
  assign o_dmem_addr  = {i_alu_resultM[XLEN-1:2], 2'b00};
  assign o_dmem_wstrb = i_ctrl_mem_byte_selM << i_alu_resultM[1:0];
  assign o_dmem_wdata = i_mem_writedataM << {i_alu_resultM[1:0], 3'b000};

`ifdef DMEM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_wait_cnt;
  logic                 r_bus_err;

  // An ack in the same cycle as the limit wins over the abort.
  assign w_timeout = (r_state == S_WAIT) & ~i_dmem_ack &
                     (r_wait_cnt == TIMEOUT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
      if ((r_state == S_WAIT) && !i_dmem_ack && !w_timeout)
        r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
      else
        r_wait_cnt <= '0;
    end
  end

  assign o_bus_err = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign o_bus_err = 1'b0;
`endif

  load_extract u_load_extract (
    .i_rdata    (i_dmem_rdata),
    .i_addr_lo  (i_alu_resultM[1:0]),
    .i_byte_sel (i_ctrl_mem_byte_selM),
    .i_unsigned (i_ctrl_mem_unsignedM),
    .o_data     (w_load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_access && !i_dmem_ack) r_state <= S_WAIT;
        S_WAIT:  if (i_dmem_ack || w_timeout || !w_access) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // M/W register. Stalled, misaligned and aborted cycles insert a bubble:
  // only the write enable is cleared, the other fields hold their value.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_ctrl_reg_wr_enW  <= 1'b0;
      o_ctrl_result_srcW <= '0;
      o_alu_resultW      <= '0;
      o_read_dataW       <= '0;
      o_regfile_rd_addrW <= '0;
      o_PCPlus4W         <= '0;
      o_misaligned       <= 1'b0;
    end else begin
      o_misaligned <= w_misalign_acc;
      if (w_stall || w_misalign_acc || w_timeout) begin
        o_ctrl_reg_wr_enW <= 1'b0;
      end else begin
        o_ctrl_reg_wr_enW  <= i_ctrl_reg_wr_enM;
        o_ctrl_result_srcW <= i_ctrl_result_srcM;
        o_alu_resultW      <= i_alu_resultM;
        o_read_dataW       <= w_load_data;
        o_regfile_rd_addrW <= i_regfile_rd_addrM;
        o_PCPlus4W         <= i_PCPlus4M;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_mem_access.sv
// Scoreboard bench for pipeline_mem_access. A driver issues M-stage
// operations and pushes the expected bus transaction and W-register result;
// a responder emulates a variable-latency data memory; a monitor pops and
// compares whenever the DUT presents a bus completion or a W write.
module tb_pipeline_mem_access;
  import pipeline_mem_access_pkg::*;

  logic            i_clk = 1'b0;
  logic            i_rstn;
  logic            i_ctrl_reg_wr_enM;
  logic [1:0]      i_ctrl_result_srcM;
  logic            i_ctrl_mem_wr_enM;
  logic [3:0]      i_ctrl_mem_byte_selM;
  logic            i_ctrl_mem_unsignedM;
  logic [31:0]     i_alu_resultM;
  logic [31:0]     i_mem_writedataM;
  logic [4:0]      i_regfile_rd_addrM;
  logic [31:0]     i_PCPlus4M;
  logic            o_dmem_req, o_dmem_we;
  logic [31:0]     o_dmem_addr;
  logic [3:0]      o_dmem_wstrb;
  logic [31:0]     o_dmem_wdata;
  logic            i_dmem_ack;
  logic [31:0]     i_dmem_rdata;
  logic            o_stallM, o_misaligned, o_bus_err;
  logic            o_ctrl_reg_wr_enW;
  logic [1:0]      o_ctrl_result_srcW;
  logic [31:0]     o_alu_resultW, o_read_dataW, o_PCPlus4W;
  logic [4:0]      o_regfile_rd_addrW;

  always #5 i_clk = ~i_clk;

  pipeline_mem_access #(.TIMEOUT_CYCLES(255), .TIMEOUT_W(8)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_ctrl_reg_wr_enM(i_ctrl_reg_wr_enM), .i_ctrl_result_srcM(i_ctrl_result_srcM),
    .i_ctrl_mem_wr_enM(i_ctrl_mem_wr_enM), .i_ctrl_mem_byte_selM(i_ctrl_mem_byte_selM),
    .i_ctrl_mem_unsignedM(i_ctrl_mem_unsignedM), .i_alu_resultM(i_alu_resultM),
    .i_mem_writedataM(i_mem_writedataM), .i_regfile_rd_addrM(i_regfile_rd_addrM),
    .i_PCPlus4M(i_PCPlus4M),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wstrb(o_dmem_wstrb), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_stallM(o_stallM), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
    .o_ctrl_reg_wr_enW(o_ctrl_reg_wr_enW), .o_ctrl_result_srcW(o_ctrl_result_srcW),
    .o_alu_resultW(o_alu_resultW), .o_read_dataW(o_read_dataW),
    .o_regfile_rd_addrW(o_regfile_rd_addrW), .o_PCPlus4W(o_PCPlus4W)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
  } w_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_exp_t;

  w_exp_t   w_q[$];
  bus_exp_t bus_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Two independent memories: ref_mem is the specification model, bus_mem is
  // what the responder sees through the DUT's strobes and shifted data.
  logic [31:0] ref_mem[int];
  logic [31:0] bus_mem[int];

  function automatic logic [31:0] seed_word(input int widx);
    return (32'(widx) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input int widx);
    if (!ref_mem.exists(widx)) ref_mem[widx] = seed_word(widx);
    return ref_mem[widx];
  endfunction

  function automatic logic [31:0] bus_rd(input int widx);
    if (!bus_mem.exists(widx)) bus_mem[widx] = seed_word(widx);
    return bus_mem[widx];
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    w = ref_rd(int'(a >> 2));
    return w[8*int'(a[1:0]) +: 8];
  endfunction

  // Byte-by-byte load: assemble n bytes little-endian, then extend.
  function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input logic uns);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_byte(a + 32'(i))) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  function automatic void model_store(input logic [31:0] a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      logic [31:0] ba, w;
      ba = a + 32'(i);
      w  = ref_rd(int'(ba >> 2));
      w[8*int'(ba[1:0]) +: 8] = d[8*i +: 8];
      ref_mem[int'(ba >> 2)] = w;
    end
  endfunction

  // ---------------- memory responder ----------------
  int cnt = 0;
  int cur_lat = 0;
  int force_lat = -1;
  bit hold_ack = 1'b0;
  bit inj_ack = 1'b0;

  initial begin
    i_dmem_ack = 1'b0;
    i_dmem_rdata = '0;
    forever begin
      @(posedge i_clk);
      #2;
      if (!i_rstn) begin
        cnt = 0;
        i_dmem_ack = 1'b0;
      end else if (inj_ack) begin
        i_dmem_ack = 1'b1;
        i_dmem_rdata = $urandom;
      end else if (o_dmem_req && !hold_ack) begin
        if (cnt == 0) cur_lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        if (cnt == cur_lat) begin
          int widx;
          logic [31:0] w;
          widx = int'(o_dmem_addr >> 2);
          w = bus_rd(widx);
          i_dmem_ack = 1'b1;
          i_dmem_rdata = w;
          if (o_dmem_we) begin
            for (int b = 0; b < 4; b++)
              if (o_dmem_wstrb[b]) w[8*b +: 8] = o_dmem_wdata[8*b +: 8];
            bus_mem[widx] = w;
          end
          cnt = 0;
        end else begin
          i_dmem_ack = 1'b0;
          i_dmem_rdata = $urandom;
          cnt++;
        end
      end else begin
        i_dmem_ack = 1'b0;
        i_dmem_rdata = $urandom;
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_mis = 1'b0;

  initial begin
    w_exp_t   we_;
    bus_exp_t be_;
    forever begin
      @(negedge i_clk);
      if (!i_rstn) begin
        prev_mis = 1'b0;
      end else begin
        if (o_ctrl_reg_wr_enW) begin
          if (w_q.size() == 0) begin
            check("w_unexpected_write", 32'(o_ctrl_reg_wr_enW), 32'd0);
          end else begin
            we_ = w_q.pop_front();
            check("w_rd", 32'(o_regfile_rd_addrW), 32'(we_.rd));
            check("w_result_src", 32'(o_ctrl_result_srcW), 32'(we_.src));
            check("w_alu_result", o_alu_resultW, we_.alu);
            check("w_pc4", o_PCPlus4W, we_.pc4);
            if (we_.src == RESULT_SRC_MEM) check("w_read_data", o_read_dataW, we_.rdata);
          end
        end
        if (o_dmem_req && i_dmem_ack) begin
          if (bus_q.size() == 0) begin
            check("bus_unexpected_access", 32'(o_dmem_req), 32'd0);
          end else begin
            be_ = bus_q.pop_front();
            check("bus_we", 32'(o_dmem_we), 32'(be_.we));
            check("bus_addr", o_dmem_addr, be_.addr);
            if (be_.we) begin
              check("bus_wstrb", 32'(o_dmem_wstrb), 32'(be_.strb));
              check("bus_wdata", o_dmem_wdata, be_.wdata);
            end
          end
        end
        if (prev_mis || o_misaligned) check("misaligned_flag", 32'(o_misaligned), 32'(prev_mis));
        if (o_bus_err) check("bus_err", 32'(o_bus_err), 32'd0);
        // Misaligned ops never stall, so the ones presented now are consumed next edge.
        prev_mis = (i_ctrl_result_srcM == RESULT_SRC_MEM || i_ctrl_mem_wr_enM) &&
                   ((i_ctrl_mem_byte_selM == BYTE_SEL_H && i_alu_resultM[0]) ||
                    (i_ctrl_mem_byte_selM == BYTE_SEL_W && i_alu_resultM[1:0] != 2'b00));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_nop();
    i_ctrl_reg_wr_enM = 1'b0;
    i_ctrl_result_srcM = RESULT_SRC_ALU;
    i_ctrl_mem_wr_enM = 1'b0;
    i_ctrl_mem_byte_selM = BYTE_SEL_B;
    i_ctrl_mem_unsignedM = 1'b0;
    i_alu_resultM = '0;
    i_mem_writedataM = '0;
    i_regfile_rd_addrM = '0;
    i_PCPlus4M = '0;
  endtask

  task automatic run_op(input logic [1:0] src, input logic wr, input logic [3:0] bsel,
                        input logic uns, input logic [31:0] addr, input logic [31:0] data,
                        input int lat);
    int n, off, st;
    logic mem_op, mis;
    logic [3:0] strb;
    w_exp_t we_;
    bus_exp_t be_;
    @(posedge i_clk);
    #1;
    i_ctrl_reg_wr_enM = ~wr;
    i_ctrl_result_srcM = src;
    i_ctrl_mem_wr_enM = wr;
    i_ctrl_mem_byte_selM = bsel;
    i_ctrl_mem_unsignedM = uns;
    i_alu_resultM = addr;
    i_mem_writedataM = data;
    i_regfile_rd_addrM = 5'($urandom_range(1, 31));
    i_PCPlus4M = $urandom;
    force_lat = lat;

    n = (bsel == BYTE_SEL_B) ? 1 : (bsel == BYTE_SEL_H) ? 2 : 4;
    off = int'(addr[1:0]);
    mem_op = (src == RESULT_SRC_MEM) || wr;
    mis = mem_op && ((n == 2 && off[0]) || (n == 4 && off != 0));

    if (mem_op && !mis) begin
      strb = '0;
      for (int i = 0; i < n; i++) if (off + i < 4) strb[off+i] = 1'b1;
      be_.we = wr;
      be_.addr = addr & ~32'h3;
      be_.strb = strb;
      be_.wdata = data << (8 * off);
      bus_q.push_back(be_);
    end
    if (!wr && !mis) begin
      we_.rd = i_regfile_rd_addrM;
      we_.src = src;
      we_.alu = addr;
      we_.pc4 = i_PCPlus4M;
      we_.rdata = (src == RESULT_SRC_MEM) ? model_load(addr, n, uns) : 32'h0;
      w_q.push_back(we_);
    end
    if (wr && !mis) model_store(addr, n, data);

    st = 0;
    forever begin
      @(negedge i_clk);
      if (mis) check("no_req_when_misaligned", 32'(o_dmem_req), 32'd0);
      if (!o_stallM) break;
      if (st > 0) check("w_bubble_while_stalled", 32'(o_ctrl_reg_wr_enW), 32'd0);
      st++;
      if (st > 30) begin
        $display("FAIL stall_bound actual=%0d required<=3", st);
        $fatal(1, "stall never released");
      end
    end
    check("stall_cycles", 32'(st), (mem_op && !mis) ? 32'(cur_lat) : 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    i_rstn = 1'b0;
    drive_nop();
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_reg_wr_enW", 32'(o_ctrl_reg_wr_enW), 32'd0);
    check("rst_alu_resultW", o_alu_resultW, 32'd0);
    check("rst_read_dataW", o_read_dataW, 32'd0);
    check("rst_pc4W", o_PCPlus4W, 32'd0);
    check("rst_misaligned", 32'(o_misaligned), 32'd0);
    check("rst_bus_err", 32'(o_bus_err), 32'd0);
    check("rst_req", 32'(o_dmem_req), 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // LB 0x1003 from word 0x80FF_1234, zero-wait ack -> 0xFFFF_FF80.
    ref_mem[32'h1000 >> 2] = 32'h80FF_1234;
    bus_mem[32'h1000 >> 2] = 32'h80FF_1234;
    run_op(RESULT_SRC_MEM, 1'b0, BYTE_SEL_B, 1'b0, 32'h0000_1003, 32'h0, 0);
    // SH 0x2002 0xBEEF, ack after 3 cycles.
    run_op(RESULT_SRC_ALU, 1'b1, BYTE_SEL_H, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 3);
    // LHU 0x2001: misaligned.
    run_op(RESULT_SRC_MEM, 1'b0, BYTE_SEL_H, 1'b1, 32'h0000_2001, 32'h0, -1);
    // ADD result 0x55.
    run_op(RESULT_SRC_ALU, 1'b0, BYTE_SEL_B, 1'b0, 32'h0000_0055, 32'h0, -1);
    // Read back the stored half through a signed LH.
    run_op(RESULT_SRC_MEM, 1'b0, BYTE_SEL_H, 1'b0, 32'h0000_2002, 32'h0, 1);

    // Reset in the middle of a WAIT.
    hold_ack = 1'b1;
    @(posedge i_clk);
    #1;
    i_ctrl_reg_wr_enM = 1'b1;
    i_ctrl_result_srcM = RESULT_SRC_MEM;
    i_ctrl_mem_byte_selM = BYTE_SEL_W;
    i_alu_resultM = 32'h0000_1010;
    i_regfile_rd_addrM = 5'd7;
    @(negedge i_clk);
    check("lw_stall_idle", 32'(o_stallM), 32'd1);
    @(negedge i_clk);
    check("lw_stall_wait", 32'(o_stallM), 32'd1);
    i_rstn = 1'b0;
    #1;
    check("rst_mid_wait_req", 32'(o_dmem_req), 32'd0);
    check("rst_mid_wait_stall", 32'(o_stallM), 32'd0);
    check("rst_mid_wait_wr_enW", 32'(o_ctrl_reg_wr_enW), 32'd0);
    check("rst_mid_wait_rdW", 32'(o_regfile_rd_addrW), 32'd0);
    check("rst_mid_wait_aluW", o_alu_resultW, 32'd0);
    drive_nop();
    w_q.delete();
    bus_q.delete();
    hold_ack = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
    inj_ack = 1'b1;
    @(negedge i_clk);
    check("late_ack_no_stall", 32'(o_stallM), 32'd0);
    check("late_ack_no_req", 32'(o_dmem_req), 32'd0);
    @(posedge i_clk);
    #1;
    inj_ack = 1'b0;
    @(negedge i_clk);
    check("late_ack_no_w_write", 32'(o_ctrl_reg_wr_enW), 32'd0);

    // Randomized mix.
    for (int k = 0; k < 300; k++) begin
      int kind;
      logic [3:0] bsel;
      kind = int'($urandom_range(0, 5));
      case ($urandom_range(0, 2))
        0:       bsel = BYTE_SEL_B;
        1:       bsel = BYTE_SEL_H;
        default: bsel = BYTE_SEL_W;
      endcase
      case (kind)
        0: run_op(RESULT_SRC_ALU, 1'b0, BYTE_SEL_B, 1'b0, $urandom, $urandom, -1);
        1: run_op(RESULT_SRC_PC4, 1'b0, BYTE_SEL_B, 1'b0, $urandom, $urandom, -1);
        2, 3: run_op(RESULT_SRC_MEM, 1'b0, bsel, 1'($urandom),
                     32'h1000 + 32'($urandom_range(0, 63)), $urandom, -1);
        default: run_op(RESULT_SRC_ALU, 1'b1, bsel, 1'b0,
                        32'h1000 + 32'($urandom_range(0, 63)), $urandom, -1);
      endcase
    end

    @(posedge i_clk);
    #1;
    drive_nop();
    repeat (3) @(negedge i_clk);
    check("w_queue_drained", 32'(w_q.size()), 32'd0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
